exp4_fluxo_dados: RTL



---
 rtl/exp4_fluxo_dados_if.sv | 23 ++
 rtl/exp4_fluxo_dados.sv | 78 +++++++
 2 files changed

// File: rtl/exp4_fluxo_dados_if.sv
// rtl/exp4_fluxo_dados_if.sv - control/status bundle between the control unit and the datapath
interface exp4_fluxo_dados_if;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic [3:0] chaves;
  logic       fimC;
  logic       igual;
  logic [3:0] db_contagem;
  logic [3:0] db_memoria;
  logic [3:0] db_chaves;

  modport master (
    output zeraC, contaC, zeraR, registraR, chaves,
    input  fimC, igual, db_contagem, db_memoria, db_chaves
  );

  modport slave (
    input  zeraC, contaC, zeraR, registraR, chaves,
    output fimC, igual, db_contagem, db_memoria, db_chaves
  );
endinterface

// File: rtl/exp4_fluxo_dados.sv
// rtl/exp4_fluxo_dados.sv - address counter, answer ROM, switch register and comparator
module exp4_fluxo_dados #(
  parameter int unsigned CONT_MAX = 15
) (
  input logic               clock,
  input logic               reset,
  exp4_fluxo_dados_if.slave bus
);

  localparam logic [3:0] CONT_MAX_W = 4'(CONT_MAX);

  logic [3:0] contagem_q, contagem_d;
  logic [3:0] chaves_q, chaves_d;
  logic [3:0] memoria;

  // Wrap at CONT_MAX so the address never leaves 0..CONT_MAX.
  always_comb begin
    contagem_d = contagem_q;
    if (bus.zeraC) begin
      contagem_d = 4'd0;
    end else if (bus.contaC) begin
      if (contagem_q == CONT_MAX_W) begin
        contagem_d = 4'd0;
      end else begin
        contagem_d = contagem_q + 4'd1;
      end
    end
  end

  always_comb begin
    chaves_d = chaves_q;
    if (bus.zeraR) begin
      chaves_d = 4'd0;
    end else if (bus.registraR) begin
      chaves_d = bus.chaves;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem_q <= 4'd0;
      chaves_q   <= 4'd0;
    end else begin
      contagem_q <= contagem_d;
      chaves_q   <= chaves_d;
    end
  end

  always_comb begin
    memoria = 4'b0001;
    case (contagem_q)
      4'h0: memoria = 4'b0001;
      4'h1: memoria = 4'b0010;
      4'h2: memoria = 4'b0100;
      4'h3: memoria = 4'b1000;
      4'h4: memoria = 4'b0100;
      4'h5: memoria = 4'b0010;
      4'h6: memoria = 4'b0001;
      4'h7: memoria = 4'b0001;
      4'h8: memoria = 4'b0010;
      4'h9: memoria = 4'b0010;
      4'hA: memoria = 4'b0100;
      4'hB: memoria = 4'b0100;
      4'hC: memoria = 4'b1000;
      4'hD: memoria = 4'b1000;
      4'hE: memoria = 4'b0001;
      4'hF: memoria = 4'b0100;
      default: memoria = 4'b0001;
    endcase
  end

  assign bus.fimC        = (contagem_q == CONT_MAX_W);
  assign bus.igual       = (chaves_q == memoria);
  assign bus.db_contagem = contagem_q;
  assign bus.db_memoria  = memoria;
  assign bus.db_chaves   = chaves_q;

endmodule
